load_unit: RTL and testbench

- Read-side counterpart to the byte-store path of the data memory; executes RISC-V loads (lb, lh, lw, lbu, lhu) against a byte-wide synchronous read port.
- Fetches 1, 2 or 4 bytes on consecutive cycles, assembles them little-endian, then sign- or zero-extends the result to 32 bits.
- Sits between the CPU memory stage and the data-memory read port. Uses a valid/ready request handshake and a valid/ready response handshake.

---
 rtl/load_unit.sv | 141 ++++++++++++++
 tb/tb_load_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// RISC-V load unit: fetches 1/2/4 bytes from a byte-wide synchronous read port,
// assembles them little-endian and sign/zero-extends the result to 32 bits.
module load_unit #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_LEN       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [2:0]                req_funct3,
  output logic                      mem_re,
  output logic [ADDRESS_LENGTH-1:0] mem_addr,
  input  logic [BYTE_LEN-1:0]       mem_rdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                    state_r;
  logic [2:0]                cnt_r;
  logic [2:0]                funct3_r;
  logic [ADDRESS_LENGTH-1:0] base_r;
  logic [DATA_WIDTH-1:0]     asm_r;

  logic [2:0]                n_s;
  logic [2:0]                cnt_next_s;
  logic [1:0]                lane_s;
  logic [DATA_WIDTH-1:0]     full_s;

  // Byte count for a load type; zero marks an illegal funct3.
  function automatic logic [2:0] load_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: load_bytes = 3'd1;
      3'b001, 3'b101: load_bytes = 3'd2;
      3'b010:         load_bytes = 3'd4;
      default:        load_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                   input logic [DATA_WIDTH-1:0] w);
    case (f3)
      3'b000:  extend = {{(DATA_WIDTH-BYTE_LEN){w[BYTE_LEN-1]}}, w[BYTE_LEN-1:0]};
      3'b100:  extend = {{(DATA_WIDTH-BYTE_LEN){1'b0}}, w[BYTE_LEN-1:0]};
      3'b001:  extend = {{(DATA_WIDTH-2*BYTE_LEN){w[2*BYTE_LEN-1]}}, w[2*BYTE_LEN-1:0]};
      3'b101:  extend = {{(DATA_WIDTH-2*BYTE_LEN){1'b0}}, w[2*BYTE_LEN-1:0]};
      3'b010:  extend = w;
      default: extend = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  assign req_ready = (state_r == IDLE) && !rst;

  // Assembly word with the byte returning this cycle merged into lane cnt-1.
  always_comb begin
    n_s        = load_bytes(funct3_r);
    cnt_next_s = cnt_r + 3'd1;
    lane_s     = 2'(cnt_r - 3'd1);
    full_s     = asm_r;
    full_s[BYTE_LEN*int'(lane_s) +: BYTE_LEN] = mem_rdata;
  end

  // Load sequencing FSM with registered memory strobe and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      funct3_r   <= 3'd0;
      base_r     <= {ADDRESS_LENGTH{1'b0}};
      asm_r      <= {DATA_WIDTH{1'b0}};
      mem_re     <= 1'b0;
      mem_addr   <= {ADDRESS_LENGTH{1'b0}};
      resp_valid <= 1'b0;
      rdata      <= {DATA_WIDTH{1'b0}};
      err        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            base_r   <= req_addr;
            funct3_r <= req_funct3;
            cnt_r    <= 3'd0;
            asm_r    <= {DATA_WIDTH{1'b0}};
            if (load_bytes(req_funct3) != 3'd0) begin
              state_r  <= ISSUE;
              mem_re   <= 1'b1;
              mem_addr <= req_addr;
              err      <= 1'b0;
            end else begin
              // Illegal load type answers immediately without touching memory.
              state_r    <= RESP;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rdata      <= {DATA_WIDTH{1'b0}};
            end
          end
        end
        ISSUE: begin
          cnt_r <= cnt_next_s;
          if (cnt_r != 3'd0) begin
            asm_r <= full_s;
          end
          if (cnt_r == n_s - 3'd1) begin
            state_r <= DRAIN;
            mem_re  <= 1'b0;
          end else begin
            mem_addr <= base_r + ADDRESS_LENGTH'(cnt_next_s);
          end
        end
        DRAIN: begin
          asm_r      <= full_s;
          rdata      <= extend(funct3_r, full_s);
          err        <= 1'b0;
          resp_valid <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against an arithmetic load model
// backed by a sparse byte memory.
module tb_load_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [logic [31:0]];

  load_unit #(.ADDRESS_LENGTH(32), .DATA_WIDTH(32), .BYTE_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .rdata(rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // Synchronous byte read port; idle cycles return noise.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rd(mem_addr);
    else        mem_rdata <= 8'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3,
                                           output logic e);
    longint v;
    int     n;
    bit     sgn;
    v   = 0;
    n   = ref_len(f3);
    sgn = (f3 == 3'b000) || (f3 == 3'b001);
    e   = (n == 0);
    if (n == 0) return 32'h0;
    for (int i = 0; i < n; i++) v += longint'(rd(a + 32'(i))) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] addrs[$];
    int          n;
    int          j;
    exp_d = ref_load(a, f3, exp_e);
    n     = ref_len(f3);
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
    j = 0;
    while (!resp_valid && j < 20) begin
      if (mem_re) addrs.push_back(mem_addr);
      @(negedge clk);
      j++;
    end
    check_eq("latency", 32'(j), exp_e ? 32'd0 : 32'(n + 1));
    check_eq("mem_re_at_resp", 32'(mem_re), 32'd0);
    check_eq("n_reads", 32'(addrs.size()), 32'(n));
    for (int i = 0; i < addrs.size() && i < n; i++)
      check_eq("mem_addr", addrs[i], a + 32'(i));
    check_eq("rdata", rdata, exp_d);
    check_eq("err", 32'(err), 32'(exp_e));
    // Backpressure: response must hold while new requests are refused.
    for (int k = 0; k < hold; k++) begin
      req_valid  = 1'b1;
      req_funct3 = 3'($urandom);
      @(negedge clk);
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", rdata, exp_d);
      check_eq("hold_err", 32'(err), 32'(exp_e));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("resp_done", 32'(resp_valid), 32'd0);
    check_eq("back_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_funct3 = 3'b000; resp_ready = 1'b0;
    mem[32'h1000] = 8'h80; mem[32'h1001] = 8'h7F;
    mem[32'h1002] = 8'hAA; mem[32'h1003] = 8'h55;
    for (int i = 0; i < 64; i++) mem[32'h2000 + 32'(i)] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_mem_re", 32'(mem_re), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Directed scenarios, with literal expectations cross-checking the model.
    check_eq("model_lw", ref_load(32'h1000, 3'b010, f3[0]), 32'h55AA7F80);
    check_eq("model_lb", ref_load(32'h1000, 3'b000, f3[0]), 32'hFFFFFF80);
    check_eq("model_lh", ref_load(32'h1001, 3'b001, f3[0]), 32'hFFFFAA7F);
    check_eq("model_lh2", ref_load(32'h1002, 3'b001, f3[0]), 32'h000055AA);
    run_load(32'h1000, 3'b010, 0);
    run_load(32'h1000, 3'b000, 0);
    run_load(32'h1000, 3'b100, 0);
    run_load(32'h1001, 3'b000, 0);
    run_load(32'h1001, 3'b001, 0);
    run_load(32'h1001, 3'b101, 0);
    run_load(32'h1002, 3'b001, 0);
    run_load(32'h1000, 3'b011, 0);
    run_load(32'h1000, 3'b110, 0);
    run_load(32'h1000, 3'b111, 0);
    run_load(32'h1000, 3'b010, 3);

    // Reset in the middle of a word load discards it.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_mem_re", 32'(mem_re), 32'd0);
    check_eq("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_no_resp", 32'(resp_valid), 32'd0);
    run_load(32'h1003, 3'b100, 0);
    check_eq("model_lbu3", ref_load(32'h1003, 3'b100, f3[0]), 32'h00000055);

    run_load(32'hFFFFFFFE, 3'b010, 1);
    run_load(32'hFFFFFFFF, 3'b101, 0);

    for (int t = 0; t < 60; t++) begin
      f3 = 3'($urandom);
      if ($urandom_range(0, 1) == 0) a = 32'h2000 + 32'($urandom_range(0, 60));
      else a = $urandom;
      run_load(a, f3, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
